// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array operand feeder.
package systolic_pkg;

    localparam int unsigned DEFAULT_N = 4;
    localparam int unsigned DEFAULT_W = 8;

    typedef logic [DEFAULT_W-1:0] fp8_t;

    // All-zero bit pattern; the PE adder treats it as +0.
    localparam fp8_t FP8_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/fp8_vec_buffer.sv
// N-slot operand buffer: one column write port, one read slot per lane.
module fp8_vec_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned W  = DEFAULT_W,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [SW-1:0]   wr_slot,
    input  logic [N*W-1:0]  wr_data,
    input  logic [N*SW-1:0] rd_slot,
    output logic [N*W-1:0]  rd_data
);

    logic [N*W-1:0] mem_q [N];

    // Contents are intentionally not reset; a fresh load always overwrites them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_slot] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rd_data[i*W +: W] = mem_q[rd_slot[i*SW +: SW]][i*W +: W];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers an NxN operand matrix and streams it as N skewed, zero-padded lanes.
// Optional SYSTOLIC_FEEDER_DRAIN_EN appends N all-zero valid beats after the stream.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           start,
    output logic [N*W-1:0] out_data,
    output logic           out_valid,
    output logic           busy,
    output logic           done
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned TW = $clog2(2*N - 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(2*N - 2);

    feeder_state_e  state_q, state_d;
    logic [SW-1:0]  count_q, count_d;
    logic [TW-1:0]  t_q, t_d;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    logic [SW-1:0]  drain_q, drain_d;
`endif
    logic [N*W-1:0] out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           xfer;
    logic [N*SW-1:0] rd_slot;
    logic [N*W-1:0]  rd_data;
    logic [N*W-1:0]  lanes;

    assign in_ready  = (state_q == ST_IDLE || state_q == ST_LOAD) && !rst;
    assign xfer      = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    fp8_vec_buffer #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (xfer),
        .wr_slot (count_q),
        .wr_data (in_data),
        .rd_slot (rd_slot),
        .rd_data (rd_data)
    );

    // Lane i reads slot t-i while that lies in 0..N-1, otherwise pads with zero.
    always_comb begin
        rd_slot = '0;
        lanes   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (t_q >= TW'(i) && (t_q - TW'(i)) < TW'(N)) begin
                rd_slot[i*SW +: SW] = SW'(t_q - TW'(i));
                lanes[i*W +: W]     = rd_data[i*W +: W];
            end else begin
                lanes[i*W +: W]     = FP8_ZERO;
            end
        end
    end

    // Outputs are registered, so the beat for index t is loaded on the edge that
    // leaves FULL (t=0) or on each STREAM edge; t_q always names the next beat.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        t_d         = t_q;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
        drain_d     = drain_q;
`endif
        out_data_d  = '0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    count_d = SW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (count_q == CNT_LAST) begin
                        state_d = ST_FULL;
                    end else begin
                        count_d = count_q + SW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (start) begin
                    out_data_d  = lanes;
                    out_valid_d = 1'b1;
                    t_d         = t_q + TW'(1);
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_data_d  = lanes;
                out_valid_d = 1'b1;
                if (t_q == T_LAST) begin
                    t_d = '0;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
                    drain_d = '0;
                    state_d = ST_DRAIN;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
            ST_DRAIN: begin
                out_valid_d = 1'b1;
                if (drain_q == CNT_LAST) begin
                    drain_d = '0;
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + SW'(1);
                end
            end
`endif
            ST_DONE: begin
                done_d  = 1'b1;
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = out_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            t_q         <= '0;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
            drain_q     <= '0;
`endif
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            t_q         <= t_d;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
            drain_q     <= drain_d;
`endif
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (N=4, W=8).
module tb_systolic_feeder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
    localparam int NB = 11;
`else
    localparam int NB = 7;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           start;
    logic [N*W-1:0] out_data;
    logic           out_valid;
    logic           busy;
    logic           done;

    int n_tests = 0;
    int n_fail  = 0;

    // A[i][k] = {i+1, k+1}; lane 0 in bits 7:0.
    logic [31:0] exp_tbl [7] = '{
        32'h0000_0011, 32'h0000_2112, 32'h0031_2213, 32'h4132_2314,
        32'h4233_2400, 32'h4334_0000, 32'h4400_0000
    };

    systolic_feeder #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] col(input int unsigned k);
        logic [31:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c[i*8 +: 8] = {4'(i + 1), 4'(k + 1)};
        end
        return c;
    endfunction

    // start is driven high on every beat when with_start is set and left as-is afterwards.
    task automatic load4(input bit with_start);
        for (int unsigned k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = col(k);
            start    = with_start;
            tick();
            chk("load_ready", 32'(in_ready), (k == N - 1) ? 32'd0 : 32'd1);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic stream_check(input string tag, input bit hold_in);
        logic [31:0] exp_d;
        start = 1'b1;
        if (hold_in) begin
            in_valid = 1'b1;
            in_data  = 32'hEEEE_EEEE;
        end
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= NB + 2; cyc++) begin
            if (cyc <= NB) begin
                exp_d = (cyc <= 7) ? exp_tbl[cyc-1] : 32'h0;
                chk({tag, "_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_busy"},  32'(busy),      32'd1);
                chk({tag, "_done"},  32'(done),      32'd0);
                chk({tag, "_data"},  out_data,       exp_d);
                if (hold_in) chk({tag, "_ready"}, 32'(in_ready), 32'd0);
            end else if (cyc == NB + 1) begin
                chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
                chk({tag, "_end_done"},  32'(done),      32'd1);
                chk({tag, "_end_busy"},  32'(busy),      32'd0);
                chk({tag, "_end_data"},  out_data,       32'h0);
                if (hold_in) begin
                    chk({tag, "_end_ready"}, 32'(in_ready), 32'd1);
                    in_valid = 1'b0;
                end
            end else begin
                chk({tag, "_post_done"},  32'(done),      32'd0);
                chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        int nvalid;
        int ndone;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        tick();
        tick();
        chk("rst_data",  out_data,         32'h0);
        chk("rst_valid", 32'(out_valid),   32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_ready", 32'(in_ready),    32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd1);

        // start in IDLE, during LOAD and with the final beat: all ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_start_valid", 32'(out_valid), 32'd0);
        chk("idle_start_ready", 32'(in_ready),  32'd1);
        load4(1'b1);
        start = 1'b0;
        tick();
        tick();
        chk("full_wait_valid", 32'(out_valid), 32'd0);
        chk("full_wait_busy",  32'(busy),      32'd0);
        chk("full_ready",      32'(in_ready),  32'd0);
        stream_check("s1", 1'b0);

        // in_valid held through FULL/STREAM; next load right after done
        load4(1'b0);
        in_valid = 1'b1;
        in_data  = 32'hEEEE_EEEE;
        tick();
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        stream_check("s2", 1'b1);
        load4(1'b0);
        stream_check("s3", 1'b0);

        // partial load aborted by reset
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("pr_valid", 32'(out_valid), 32'd0);
        load4(1'b0);
        stream_check("s4", 1'b0);

        // reset in the middle of a stream
        load4(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ms_data", out_data, exp_tbl[c]);
            if (c == 2) rst = 1'b1;
            tick();
        end
        chk("ms_valid", 32'(out_valid), 32'd0);
        chk("ms_data0", out_data,       32'h0);
        chk("ms_busy",  32'(busy),      32'd0);
        chk("ms_done",  32'(done),      32'd0);
        rst = 1'b0;
        #1;
        chk("ms_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ms_nodone",  32'(done),      32'd0);
            chk("ms_novalid", 32'(out_valid), 32'd0);
        end

        // start held high: exactly one stream per load
        start = 1'b1;
        load4(1'b1);
        nvalid = 0;
        ndone  = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (out_valid) nvalid++;
            if (done) ndone++;
        end
        start = 1'b0;
        chk("hold_start_beats", 32'(nvalid), 32'(NB));
        chk("hold_start_done",  32'(ndone),  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
